// File: rtl/id_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_ctrl_pkg
// Description : Shared encodings for the decode-stage controller: RV32I
//               opcodes, immediate-select codes used by immediate_generate,
//               and the bubble-insertion FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package id_stage_ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    // Immediate formats understood by immediate_generate
    typedef enum logic [2:0] {
        I_SIGNED_TYPE   = 3'd0,
        I_UNSIGNED_TYPE = 3'd1,
        I_SHIFT_TYPE    = 3'd2,
        S_TYPE          = 3'd3,
        B_TYPE          = 3'd4,
        U_TYPE          = 3'd5,
        J_TYPE          = 3'd6
    } imm_sel_e;

    // Load-use bubble FSM
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

endpackage : id_stage_ctrl_pkg
`default_nettype wire

// File: rtl/id_stage_ctrl_immediate_generate.sv
`default_nettype none
// ============================================================================
// Module      : immediate_generate
// Description : Purely combinational RV32I immediate extraction.
//   instr   in  [31:7] instruction bits above the opcode
//   imm_sel in  3      immediate format
//   imm     out 32     sign/zero-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module immediate_generate
    import id_stage_ctrl_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    imm_sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (imm_sel)
            I_SIGNED_TYPE:   imm = {{20{instr[31]}}, instr[31:20]};
            I_UNSIGNED_TYPE: imm = {20'd0, instr[31:20]};
            I_SHIFT_TYPE:    imm = {27'd0, instr[24:20]};
            S_TYPE:          imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:          imm = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            U_TYPE:          imm = {instr[31:12], 12'd0};
            J_TYPE:          imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            default:         imm = 32'd0;
        endcase
    end

endmodule : immediate_generate
`default_nettype wire

// File: rtl/id_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_ctrl
// Description : Decode-stage controller. Accepts instructions from fetch over
//               valid/ready, classifies the opcode, registers decoded fields
//               and the immediate into the ID/EX register, inserts a single
//               bubble on load-use hazards, honours flush and EX backpressure,
//               and counts fetch stall cycles (saturating).
//   clk, reset_n                 clock / async active-low reset
//   if_valid, if_ready           fetch handshake
//   if_instr, if_pc              offered instruction and its address
//   flush                        redirect from EX, kills incoming and held
//   ex_ready                     EX consumes the ID/EX register
//   id_valid .. id_illegal       registered ID/EX outputs
//   stall_cnt                    saturating count of fetch stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_imm,
    output logic [2:0]             id_imm_sel,
    output logic [4:0]             id_rs1,
    output logic [4:0]             id_rs2,
    output logic [4:0]             id_rd,
    output logic [6:0]             id_opcode,
    output logic                   id_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_id_valid;
    logic [31:0]            r_pc;
    logic [31:0]            r_imm;
    logic [2:0]             r_imm_sel;
    logic [4:0]             r_rs1;
    logic [4:0]             r_rs2;
    logic [4:0]             r_rd;
    logic [6:0]             r_opcode;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    imm_sel_e    w_imm_sel;
    logic        w_illegal;
    logic        w_zero_imm;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [31:0] w_imm_gen;
    logic        w_hazard;
    logic        w_advance;
    logic        w_if_ready;
    logic        w_accept;

    assign w_opcode = if_instr[6:0];
    assign w_funct3 = if_instr[14:12];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];
    assign w_rd     = if_instr[11:7];

    // Opcode classification and register-usage flags for hazard detection
    always_comb begin
        w_imm_sel  = I_SIGNED_TYPE;
        w_illegal  = 1'b0;
        w_zero_imm = 1'b0;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b0;
        case (w_opcode)
            LUI, AUIPC: begin
                w_imm_sel = U_TYPE;
                w_use_rs1 = 1'b0;
            end
            JAL: begin
                w_imm_sel = J_TYPE;
                w_use_rs1 = 1'b0;
            end
            JALR, LOAD: w_imm_sel = I_SIGNED_TYPE;
            STORE: begin
                w_imm_sel = S_TYPE;
                w_use_rs2 = 1'b1;
            end
            BRANCH: begin
                w_imm_sel = B_TYPE;
                w_use_rs2 = 1'b1;
            end
            OP_IMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    w_imm_sel = I_SHIFT_TYPE;
            end
            OP: begin
                w_zero_imm = 1'b1;
                w_use_rs2  = 1'b1;
            end
            default: begin
                w_illegal  = 1'b1;
                w_zero_imm = 1'b1;
            end
        endcase
    end

    immediate_generate u_immediate_generate (
        .instr   (if_instr[31:7]),
        .imm_sel (w_imm_sel),
        .imm     (w_imm_gen)
    );

    // Load result is not forwardable the cycle after it sits in ID/EX
    assign w_hazard = r_id_valid && (r_opcode == LOAD) && (r_rd != 5'd0) &&
                      ((w_use_rs1 && (w_rs1 == r_rd)) ||
                       (w_use_rs2 && (w_rs2 == r_rd)));

    assign w_advance = !r_id_valid || ex_ready;

    always_comb begin
        w_state_next = r_state;
        w_if_ready   = w_advance;
        if (flush) begin
            // Accept-and-drop so fetch drains during a redirect
            w_if_ready   = 1'b1;
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (if_valid && w_hazard) begin
                        w_if_ready = 1'b0;
                        if (ex_ready)
                            w_state_next = BUBBLE;
                    end
                end
                BUBBLE:  w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    assign w_accept = if_valid && w_if_ready && !flush;
    assign if_ready = w_if_ready && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_id_valid  <= 1'b0;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_imm_sel   <= 3'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_opcode    <= 7'd0;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_id_valid <= 1'b0;
            end else if (w_advance) begin
                // A hazard leaves w_accept low here, which is the bubble
                r_id_valid <= w_accept;
                if (w_accept) begin
                    r_pc      <= if_pc;
                    r_imm     <= w_zero_imm ? 32'd0 : w_imm_gen;
                    r_imm_sel <= w_imm_sel;
                    r_rs1     <= w_rs1;
                    r_rs2     <= w_rs2;
                    r_rd      <= w_rd;
                    r_opcode  <= w_opcode;
                    r_illegal <= w_illegal;
                end
            end
            if (if_valid && !w_if_ready && !flush && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign id_valid   = r_id_valid;
    assign id_pc      = r_pc;
    assign id_imm     = r_imm;
    assign id_imm_sel = r_imm_sel;
    assign id_rs1     = r_rs1;
    assign id_rs2     = r_rs2;
    assign id_rd      = r_rd;
    assign id_opcode  = r_opcode;
    assign id_illegal = r_illegal;
    assign stall_cnt  = r_stall_cnt;

endmodule : id_stage_ctrl
`default_nettype wire

// File: tb/tb_id_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_ctrl
// Description : Directed self-checking bench for id_stage_ctrl with a
//               scoreboard of expected ID/EX contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_ctrl;
    import id_stage_ctrl_pkg::*;

    localparam int STALL_CNT_W = 16;

    logic                   clk;
    logic                   reset_n;
    logic                   if_valid;
    logic                   if_ready;
    logic [31:0]            if_instr;
    logic [31:0]            if_pc;
    logic                   flush;
    logic                   ex_ready;
    logic                   id_valid;
    logic [31:0]            id_pc;
    logic [31:0]            id_imm;
    logic [2:0]             id_imm_sel;
    logic [4:0]             id_rs1;
    logic [4:0]             id_rs2;
    logic [4:0]             id_rd;
    logic [6:0]             id_opcode;
    logic                   id_illegal;
    logic [STALL_CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_total;
    int   n_bad;

    id_stage_ctrl #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_imm     (id_imm),
        .id_imm_sel (id_imm_sel),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_opcode  (id_opcode),
        .id_illegal (id_illegal),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference decode, written directly from the RV32I encodings
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        e.op  = i[6:0];
        e.ill = 1'b0;
        e.sel = I_SIGNED_TYPE;
        e.imm = 32'd0;
        case (i[6:0])
            7'h37, 7'h17: begin
                e.sel = U_TYPE;
                e.imm = {i[31:12], 12'h000};
            end
            7'h6F: begin
                e.sel = J_TYPE;
                e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h23: begin
                e.sel = S_TYPE;
                e.imm = {{21{i[31]}}, i[30:25], i[11:7]};
            end
            7'h63: begin
                e.sel = B_TYPE;
                e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h03, 7'h67: e.imm = {{21{i[31]}}, i[30:20]};
            7'h13: begin
                if (i[14:12] == 3'b001 || i[14:12] == 3'b101) begin
                    e.sel = I_SHIFT_TYPE;
                    e.imm = {27'd0, i[24:20]};
                end else begin
                    e.imm = {{21{i[31]}}, i[30:20]};
                end
            end
            7'h33: e.imm = 32'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drive, check if_ready at the falling
    // edge, clock, then check the ID/EX register against the scoreboard.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic exr, input logic fl,
                        input logic exp_rdy, input logic exp_vld);
        logic acc;
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        ex_ready = exr;
        flush    = fl;
        @(negedge clk);
        chk("if_ready", {31'd0, if_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy && !fl;
        if (acc) q.push_back(model(ins, pc));
        @(posedge clk);
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, exp_vld});
        if (acc) begin
            n_total++;
            assert (q.size() > 0)
            else begin
                n_bad++;
                $error("FAIL scoreboard observed=empty expected=entry");
            end
            if (q.size() > 0) cur = q.pop_front();
        end
        if (exp_vld) begin
            chk("id_pc",      id_pc,                 cur.pc);
            chk("id_imm",     id_imm,                cur.imm);
            chk("id_imm_sel", {29'd0, id_imm_sel},   {29'd0, cur.sel});
            chk("id_rs1",     {27'd0, id_rs1},       {27'd0, cur.rs1});
            chk("id_rs2",     {27'd0, id_rs2},       {27'd0, cur.rs2});
            chk("id_rd",      {27'd0, id_rd},        {27'd0, cur.rd});
            chk("id_opcode",  {25'd0, id_opcode},    {25'd0, cur.op});
            chk("id_illegal", {31'd0, id_illegal},   {31'd0, cur.ill});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},   {31'd0, id_valid},   32'd0);
        chk({tag, "_pc"},      id_pc,               32'd0);
        chk({tag, "_imm"},     id_imm,              32'd0);
        chk({tag, "_sel"},     {29'd0, id_imm_sel}, 32'd0);
        chk({tag, "_rd"},      {27'd0, id_rd},      32'd0);
        chk({tag, "_opcode"},  {25'd0, id_opcode},  32'd0);
        chk({tag, "_illegal"}, {31'd0, id_illegal}, 32'd0);
        chk({tag, "_stall"},   {16'd0, stall_cnt},  32'd0);
        chk({tag, "_ready"},   {31'd0, if_ready},   32'd0);
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000_0013;
        if_pc    = 32'd0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADDI x1,x2,-1 ; LUI x5 ; SLLI x1,x1,5 back-to-back
        step(1'b1, 32'hFFF1_0093, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("addi_imm", id_imm, 32'hFFFF_FFFF);
        step(1'b1, 32'hABCD_E2B7, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0050_9093, 32'h108, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("stall_none", {16'd0, stall_cnt}, 32'd0);

        // LW x3 then ADD x4,x3,x2: one refused cycle, one bubble
        step(1'b1, 32'h0000_A183, 32'h10C, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0021_8233, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_loaduse", {16'd0, stall_cnt}, 32'd1);
        step(1'b1, 32'h0021_8233, 32'h110, 1'b1, 1'b0, 1'b1, 1'b1);

        // EX backpressure for 3 cycles: ADD held stable
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h0000_0013, 32'h114, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_backpressure", {16'd0, stall_cnt}, 32'd4);
        step(1'b1, 32'h0000_0013, 32'h114, 1'b1, 1'b0, 1'b1, 1'b1);

        // Flush with live ID/EX and an offered instruction
        step(1'b1, 32'h0010_0093, 32'h118, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("stall_flush", {16'd0, stall_cnt}, 32'd4);

        // Unsupported opcode still propagates
        step(1'b1, 32'h0000_007F, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);

        // LW x0 followed by a use of x0: no hazard
        step(1'b1, 32'h0000_2003, 32'h204, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0033, 32'h208, 1'b1, 1'b0, 1'b1, 1'b1);

        // LW x3 then LUI with rs1 field = 3: U-type does not read rs1
        step(1'b1, 32'h0000_A183, 32'h20C, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0001_81B7, 32'h210, 1'b1, 1'b0, 1'b1, 1'b1);

        // LW x5 then SW x5,4(x2): hazard through rs2
        step(1'b1, 32'h0000_A283, 32'h214, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0051_2223, 32'h218, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0051_2223, 32'h218, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("stall_rs2", {16'd0, stall_cnt}, 32'd5);

        // Branch and jump immediates
        step(1'b1, 32'hFE20_8EE3, 32'h21C, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("beq_imm", id_imm, 32'hFFFF_FFFC);
        step(1'b1, 32'h0080_00EF, 32'h220, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("jal_imm", id_imm, 32'h0000_0008);

        // Asynchronous reset between clock edges
        if_instr = 32'hFFF1_0093;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
        step(1'b1, 32'hFFF1_0093, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_id_stage_ctrl
`default_nettype wire
